// File: rtl/crono_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, BCD limits, defaults.
package crono_pkg;

    typedef enum logic [1:0] {
        VACIO = 2'd0,
        LISTO = 2'd1,
        CORRE = 2'd2,
        FIN   = 2'd3
    } crono_estado_t;

    localparam int unsigned TICK_DIV_DEF  = 100_000_000;
    localparam int unsigned AVISO_SEG_DEF = 10;
    localparam int unsigned SEG_DIA_MAX   = 86_399;

    localparam logic [7:0] HORA_MAX   = 8'h23;
    localparam logic [7:0] MINSEG_MAX = 8'h59;
    localparam logic [3:0] DIGITO_MAX = 4'h9;

    // Clamp a packed BCD field to its limit when a nibble is not a decimal digit
    // or the value exceeds the limit (BCD and hex ordering agree for valid digits).
    function automatic logic [7:0] sat_bcd(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        r = v;
        if ((v[7:4] > DIGITO_MAX) || (v[3:0] > DIGITO_MAX) || (v > lim)) begin
            r = lim;
        end
        return r;
    endfunction

    // Packed BCD (00..99) to binary.
    function automatic logic [6:0] bcd_a_bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

endpackage

// File: rtl/prescaler_seg.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, holds when disabled.
module prescaler_seg
    import crono_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Tick is qualified by enable so a held (paused) count never fires.
    assign tick = en && (cnt_q == CNT_MAX);

    // Fraction-of-second counter; clear wins over counting.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/contador_crono.sv
// Countdown timer HH:MM:SS in packed BCD with load, pause and end flag.
// Optional near-end warning on Aviso when built with CRONO_AVISO_EN.
module contador_crono
    import crono_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned AVISO_SEG = AVISO_SEG_DEF
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       CronoActivo,
    input  logic       ProgramarCrono,
    input  logic       Carga,
    input  logic [7:0] HoraProg,
    input  logic [7:0] MinProg,
    input  logic [7:0] SegProg,
    output logic [7:0] Hora,
    output logic [7:0] Min,
    output logic [7:0] Seg,
    output logic       FinalizoCrono,
    output logic       Aviso
);

    // Elaboration-time parameter sanity.
    if (TICK_DIV == 0) begin : g_tick_div_chk
        $error("contador_crono: TICK_DIV must be at least 1");
    end
    if (AVISO_SEG > SEG_DIA_MAX) begin : g_aviso_chk
        $error("contador_crono: AVISO_SEG exceeds one day");
    end

    crono_estado_t state_q;
    crono_estado_t state_d;
    logic [7:0]    hora_d;
    logic [7:0]    min_d;
    logic [7:0]    seg_d;
    logic          carga_c;
    logic          tick;
    logic          cero_q;
    logic          cero_d;

    // BCD decrement of a field known to be nonzero.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h0) begin
            r = {v[7:4] - 4'h1, DIGITO_MAX};
        end else begin
            r = {v[7:4], v[3:0] - 4'h1};
        end
        return r;
    endfunction

    assign carga_c = ProgramarCrono && Carga;
    assign cero_q  = ({Hora, Min, Seg} == 24'h00_0000);

    prescaler_seg #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .Reset (Reset),
        .en    (state_q == CORRE),
        .clr   (carga_c),
        .tick  (tick)
    );

    // Next state and next time value; load dominates everything else.
    always_comb begin
        state_d = state_q;
        hora_d  = Hora;
        min_d   = Min;
        seg_d   = Seg;
        cero_d  = 1'b0;

        if (carga_c) begin
            hora_d  = sat_bcd(HoraProg, HORA_MAX);
            min_d   = sat_bcd(MinProg, MINSEG_MAX);
            seg_d   = sat_bcd(SegProg, MINSEG_MAX);
            cero_d  = ({hora_d, min_d, seg_d} == 24'h00_0000);
            state_d = cero_d ? VACIO : LISTO;
        end else begin
            unique case (state_q)
                VACIO: begin
                    state_d = VACIO;
                end
                LISTO: begin
                    if (CronoActivo) begin
                        state_d = CORRE;
                    end
                end
                CORRE: begin
                    if (tick && !cero_q) begin
                        if (Seg != 8'h00) begin
                            seg_d = bcd_dec(Seg);
                        end else begin
                            seg_d = MINSEG_MAX;
                            if (Min != 8'h00) begin
                                min_d = bcd_dec(Min);
                            end else begin
                                min_d  = MINSEG_MAX;
                                hora_d = (Hora != 8'h00) ? bcd_dec(Hora) : 8'h00;
                            end
                        end
                    end
                    cero_d = ({hora_d, min_d, seg_d} == 24'h00_0000);
                    if (cero_d) begin
                        state_d = FIN;
                    end else if (!CronoActivo) begin
                        state_d = LISTO;
                    end
                end
                FIN: begin
                    state_d = FIN;
                end
                default: begin
                    state_d = VACIO;
                end
            endcase
        end
    end

    // State, time and end-flag registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= VACIO;
            Hora          <= 8'h00;
            Min           <= 8'h00;
            Seg           <= 8'h00;
            FinalizoCrono <= 1'b0;
        end else begin
            state_q       <= state_d;
            Hora          <= hora_d;
            Min           <= min_d;
            Seg           <= seg_d;
            FinalizoCrono <= (state_d == FIN);
        end
    end

`ifdef CRONO_AVISO_EN
    localparam int unsigned TOTAL_W = 17;

    logic [TOTAL_W-1:0] resto_d;
    logic               aviso_d;

    // Remaining seconds of the next value, compared against the warning window.
    always_comb begin
        resto_d = TOTAL_W'(bcd_a_bin(hora_d)) * TOTAL_W'(3600)
                + TOTAL_W'(bcd_a_bin(min_d))  * TOTAL_W'(60)
                + TOTAL_W'(bcd_a_bin(seg_d));
        aviso_d = (state_d == CORRE)
               && (resto_d <= TOTAL_W'(AVISO_SEG))
               && (resto_d != '0);
    end

    // Registered near-end warning.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Aviso <= 1'b0;
        end else begin
            Aviso <= aviso_d;
        end
    end
`else
    assign Aviso = 1'b0;
`endif

endmodule

// File: tb/tb_contador_crono.sv
// Randomized scoreboard bench for contador_crono (TICK_DIV=4, AVISO_SEG=10).
`timescale 1ns/1ps
module tb_contador_crono;

    localparam int TDIV = 4;
    localparam int AVS  = 10;

    logic       clk            = 1'b0;
    logic       Reset          = 1'b0;
    logic       CronoActivo    = 1'b0;
    logic       ProgramarCrono = 1'b0;
    logic       Carga          = 1'b0;
    logic [7:0] HoraProg       = 8'h00;
    logic [7:0] MinProg        = 8'h00;
    logic [7:0] SegProg        = 8'h00;
    logic [7:0] Hora;
    logic [7:0] Min;
    logic [7:0] Seg;
    logic       FinalizoCrono;
    logic       Aviso;

    contador_crono #(
        .TICK_DIV  (TDIV),
        .AVISO_SEG (AVS)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .CronoActivo    (CronoActivo),
        .ProgramarCrono (ProgramarCrono),
        .Carga          (Carga),
        .HoraProg       (HoraProg),
        .MinProg        (MinProg),
        .SegProg        (SegProg),
        .Hora           (Hora),
        .Min            (Min),
        .Seg            (Seg),
        .FinalizoCrono  (FinalizoCrono),
        .Aviso          (Aviso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       fin;
        logic       av;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: remaining time as plain seconds, fraction of second as a count.
    typedef enum int {M_VACIO, M_LISTO, M_CORRE, M_FIN} mst_t;
    mst_t m_st   = M_VACIO;
    int   m_rem  = 0;
    int   m_frac = 0;

    function automatic int sat_field(input logic [7:0] v, input int lim);
        int hi;
        int lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9 || lo > 9 || (hi * 10 + lo) > lim) return lim;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic snap_t expect_now();
        snap_t e;
        e.h   = to_bcd(m_rem / 3600);
        e.m   = to_bcd((m_rem / 60) % 60);
        e.s   = to_bcd(m_rem % 60);
        e.fin = (m_st == M_FIN);
`ifdef CRONO_AVISO_EN
        e.av  = (m_st == M_CORRE) && (m_rem <= AVS) && (m_rem != 0);
`else
        e.av  = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_st   = M_VACIO;
        m_rem  = 0;
        m_frac = 0;
    endtask

    task automatic model_edge(input logic rst, input logic act, input logic prog,
                              input logic carga, input logic [7:0] h,
                              input logic [7:0] m, input logic [7:0] s);
        if (!rst) begin
            model_reset();
        end else if (prog && carga) begin
            m_rem  = sat_field(h, 23) * 3600 + sat_field(m, 59) * 60 + sat_field(s, 59);
            m_frac = 0;
            m_st   = (m_rem != 0) ? M_LISTO : M_VACIO;
        end else begin
            case (m_st)
                M_LISTO: if (act) m_st = M_CORRE;
                M_CORRE: begin
                    if (m_frac == TDIV - 1) begin
                        m_frac = 0;
                        m_rem  = m_rem - 1;
                    end else begin
                        m_frac = m_frac + 1;
                    end
                    if (m_rem == 0)  m_st = M_FIN;
                    else if (!act)   m_st = M_LISTO;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock, compared on the falling edge.
    always @(negedge clk) begin : monitor
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hora", Hora, e.h);
            chk("min",  Min,  e.m);
            chk("seg",  Seg,  e.s);
            chk("finalizo", {7'b0, FinalizoCrono}, {7'b0, e.fin});
            chk("aviso",    {7'b0, Aviso},         {7'b0, e.av});
        end
    end

    // One clock of stimulus; called just after a rising edge (or at time 0).
    task automatic step(input logic rst, input logic act, input logic prog, input logic carga,
                        input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if (!rst && Reset) begin
            // Asynchronous reset clears outputs before the pending compare.
            model_reset();
            if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = expect_now();
        end
        Reset          = rst;
        CronoActivo    = act;
        ProgramarCrono = prog;
        Carga          = carga;
        HoraProg       = h;
        MinProg        = m;
        SegProg        = s;
        @(posedge clk);
        model_edge(rst, act, prog, carga, h, m, s);
        exp_q.push_back(expect_now());
        #1;
    endtask

    task automatic idle(input int n, input logic act);
        repeat (n) step(1'b1, act, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic act);
        step(1'b1, act, 1'b1, 1'b1, h, m, s);
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic async_reset_check();
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = expect_now();
        Reset = 1'b0;
        #2;
        chk("async_hora", Hora, 8'h00);
        chk("async_min",  Min,  8'h00);
        chk("async_seg",  Seg,  8'h00);
        chk("async_fin",  {7'b0, FinalizoCrono}, 8'h00);
        chk("async_aviso", {7'b0, Aviso}, 8'h00);
    endtask

    function automatic logic [7:0] rnd_field();
        logic [7:0] r;
        if ($urandom_range(0, 4) == 0) r = 8'($urandom_range(0, 255));
        else                           r = to_bcd(int'($urandom_range(0, 2)));
        return r;
    endfunction

    initial begin
        // Reset held, then released
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // 00:00:03 runs to the end and holds the end flag
        load(8'h00, 8'h00, 8'h03, 1'b0);
        idle(14 + 20, 1'b1);

        // Reload from the finished state, run briefly, then reset mid-count
        load(8'h00, 8'h00, 8'h02, 1'b1);
        idle(6, 1'b1);
        async_reset_check();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Hour borrow: 01:00:00 -> 00:59:59
        load(8'h01, 8'h00, 8'h00, 1'b0);
        idle(5, 1'b1);
        idle(3, 1'b0);

        // Pause keeps the fraction of a second
        load(8'h00, 8'h00, 8'h05, 1'b0);
        idle(6, 1'b1);
        idle(10, 1'b0);
        idle(8, 1'b1);

        // Saturation of invalid fields
        load(8'h2A, 8'h75, 8'h09, 1'b0);
        idle(2, 1'b0);
        load(8'h24, 8'h5A, 8'h60, 1'b0);
        idle(1, 1'b0);

        // Zero load goes idle and ignores run enable
        load(8'h00, 8'h00, 8'h00, 1'b1);
        idle(6, 1'b1);

        // Minute borrow
        load(8'h00, 8'h01, 8'h00, 1'b0);
        idle(7, 1'b1);

        // Load held high reloads every cycle and blocks counting
        repeat (8) load(8'h00, 8'h00, 8'h04, 1'b1);
        idle(22, 1'b1);

        // Warning window run
        load(8'h00, 8'h00, 8'h12, 1'b0);
        idle(56, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic rst;
            logic act;
            logic prog;
            logic carga;
            rst   = ($urandom_range(0, 149) != 0);
            act   = ($urandom_range(0, 7) != 0);
            prog  = ($urandom_range(0, 5) == 0);
            carga = ($urandom_range(0, 2) == 0);
            step(rst, act, prog, carga, rnd_field(), rnd_field(),
                 ($urandom_range(0, 3) == 0) ? rnd_field() : to_bcd(int'($urandom_range(0, 15))));
        end

        // Drain: every expected snapshot must have been compared
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contador_crono.md
CONTADOR_CRONO -- requirements
Module: contador_crono

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second tick.
REQ-002 SHALL have parameter AVISO_SEG, default 10, remaining-seconds threshold for Aviso (used only with CRONO_AVISO_EN).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CronoActivo  input  1  run enable from the timer control FSM.
REQ-006 SHALL have port ProgramarCrono  input  1  programming mode qualifier.
REQ-007 SHALL have port Carga  input  1  load strobe, sampled only while ProgramarCrono=1.
REQ-008 SHALL have ports HoraProg, MinProg, SegProg  input  8 each  packed BCD programmed value.
REQ-009 SHALL have ports Hora, Min, Seg  output  8 each  packed BCD remaining time.
REQ-010 SHALL have port FinalizoCrono  output  1  level, countdown reached 00:00:00; feeds the control FSM.
REQ-011 SHALL have port Aviso  output  1  near-end warning.

Function
REQ-012 SHALL implement FSM states VACIO, LISTO, CORRE, FIN; FinalizoCrono=1 only in FIN.
REQ-013 Load SHALL occur on any cycle with ProgramarCrono=1 and Carga=1, from every state, with priority over tick and over all other transitions.
REQ-014 Load SHALL register the fields, clear the prescaler, enter LISTO if value nonzero, VACIO if 00:00:00.
REQ-015 Invalid load fields SHALL saturate per field: hours >23 or any nibble >9 -> 23; minutes/seconds tens >5 or any nibble >9 -> 59.
REQ-016 LISTO -> CORRE when CronoActivo=1; CORRE -> LISTO when CronoActivo=0 (pause); VACIO and FIN ignore CronoActivo.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 only in CORRE, hold its value in LISTO (pause keeps fraction), and emit a one-cycle tick at TICK_DIV-1 then wrap to 0.
REQ-018 On tick, Seg SHALL decrement in BCD; 00 borrows -> 59 and decrements Min; Min 00 borrows -> 59 and decrements Hora; Hora never underflows.
REQ-019 The tick that produces 00:00:00 SHALL also move FSM to FIN on the same edge; FinalizoCrono rises with the zero value, latency 0 cycles from the counter update.
REQ-020 FIN SHALL hold 00:00:00 and FinalizoCrono=1 until a load or reset; further CronoActivo has no effect.
REQ-021 Time outputs SHALL be registered, updating only on load or tick.
REQ-022 Carga held high for multiple cycles SHALL reload every cycle (level-sensitive) and prevent counting.

Reset
REQ-023 Reset=0 SHALL asynchronously force VACIO, Hora=Min=Seg=8'h00, FinalizoCrono=0, Aviso=0, prescaler=0.
REQ-024 Reset release SHALL take effect on the next rising clk; reset mid-count SHALL discard the programmed value.

Configuration
REQ-025 With macro CRONO_AVISO_EN defined, Aviso SHALL be registered high in CORRE while remaining total seconds <= AVISO_SEG and nonzero, low otherwise.
REQ-026 Without CRONO_AVISO_EN, Aviso SHALL be tied 0 and no comparison logic synthesized; port list unchanged.

Structure
REQ-027 Package crono_pkg SHALL hold FSM state encodings, BCD limit constants (23, 59, 9), and the TICK_DIV default.
REQ-028 Prescaler SHALL be a sub-module prescaler_seg (inputs clk, Reset, en, clr; output tick).
REQ-029 BCD decrement/borrow logic SHALL remain in contador_crono.

Verification (bench uses TICK_DIV=4)
REQ-030 Load 00:00:03, CronoActivo=1 -> Seg 03,02,01,00 every 4 cycles; FinalizoCrono=1 same edge Seg=00, held 20 cycles.
REQ-031 Load 01:00:00, one tick -> 00:59:59, FinalizoCrono=0.
REQ-032 Load 00:00:05, run 6 cycles, CronoActivo=0 for 10 cycles, resume -> next decrement after 2 more cycles (fraction kept).
REQ-033 Load HoraProg=8'h2A, MinProg=8'h75, SegProg=8'h09 -> outputs 23:59:09.
REQ-034 In FIN, ProgramarCrono=1 Carga=1 with 00:00:02 -> FinalizoCrono=0 next edge, state LISTO; Reset=0 mid-CORRE -> all outputs 0 immediately without clock.
REQ-035 CRONO_AVISO_EN, AVISO_SEG=10, load 00:00:12 running -> Aviso rises when Seg=10, falls in FIN.
